// File: rtl/proc_sequencer_pkg.sv
// proc_pkg: shared encodings for the register/ALU datapath sequencer
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_RSV = 3'd7;

    // The ALU op field equals the opcode for the arithmetic/logic instructions.
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;

    localparam logic [3:0] SEL_R   = 4'd8;
    localparam logic [3:0] SEL_IMM = 4'd9;

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TRAP} state_t;

    function automatic logic is_alu(input logic [2:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// proc_sequencer_if: instruction handshake and datapath control bundle; illegal exists only with SEQ_ILLEGAL_TRAP_EN
interface proc_sequencer_if;
    logic [15:0] iin;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  reg_enable;
    logic        A_enable;
    logic        R_enable;
    logic [3:0]  selReg;
    logic [2:0]  OpSelect;
    logic        bus_enable;
    logic        done;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    modport master (
`ifdef SEQ_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        output iin, instr_valid,
        input  instr_ready, reg_enable, A_enable, R_enable, selReg, OpSelect, bus_enable, done
    );

    modport slave (
`ifdef SEQ_ILLEGAL_TRAP_EN
        output illegal,
`endif
        input  iin, instr_valid,
        output instr_ready, reg_enable, A_enable, R_enable, selReg, OpSelect, bus_enable, done
    );
endinterface

// File: rtl/proc_sequencer_reg_onehot.sv
// reg_onehot: 3-bit register index plus enable to MSB-first one-hot (r0 -> bit 7)
module reg_onehot (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);
    assign onehot = en ? 8'h80 >> idx : 8'h00;
endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: handshaked multi-cycle controller for the register/ALU datapath; SEQ_ILLEGAL_TRAP_EN turns opcode 111 into a sticky trap
module proc_sequencer
    import proc_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    proc_sequencer_if.slave bus
);
    state_t     state, nxt;
    logic [8:0] ir;
    logic       we, ready;
    logic [2:0] op, rx, ry;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    // State register and instruction latch; only the opcode/register fields are kept since the immediate goes straight to the datapath.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.instr_valid) ir <= bus.iin[15:7];
        end
    end

    // Next-state and control decode from state and the latched instruction only.
    always_comb begin
        nxt          = IDLE;
        ready        = 1'b0;
        we           = 1'b0;
        bus.A_enable = 1'b0;
        bus.R_enable = 1'b0;
        bus.selReg   = 4'd0;
        bus.OpSelect = ALU_NONE;
        bus.bus_enable = 1'b0;
        bus.done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                nxt   = bus.instr_valid ? T1 : IDLE;
            end
            T1: begin
                if (op == OP_MV || op == OP_MVI) begin
                    bus.selReg     = op == OP_MV ? {1'b0, ry} : SEL_IMM;
                    we             = 1'b1;
                    bus.bus_enable = 1'b1;
                    bus.done       = 1'b1;
                end else if (is_alu(op)) begin
                    bus.selReg     = {1'b0, rx};
                    bus.A_enable   = 1'b1;
                    bus.bus_enable = 1'b1;
                    nxt            = T2;
                end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    nxt = op == OP_RSV ? TRAP : IDLE;
`else
                    bus.done = op == OP_RSV;
`endif
                end
            end
            T2: begin
                bus.selReg     = {1'b0, ry};
                bus.OpSelect   = op;
                bus.R_enable   = 1'b1;
                bus.bus_enable = 1'b1;
                nxt            = T3;
            end
            T3: begin
                bus.selReg     = SEL_R;
                we             = 1'b1;
                bus.bus_enable = 1'b1;
                bus.done       = 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            TRAP: nxt = TRAP;
`endif
            default: nxt = IDLE;
        endcase
    end

    assign bus.instr_ready = ready & resetn;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign bus.illegal = state == TRAP;
`endif

    reg_onehot u_onehot (
        .idx    (rx),
        .en     (we),
        .onehot (bus.reg_enable)
    );
endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Multi-cycle control sequencer for the 16-bit register/ALU datapath: eight GPRs r0..r7, accumulator A, result register R, the 10-source bus multiplexer and the ALU. It accepts one 16-bit instruction per valid/ready handshake and latches it. It then steps a state machine that drives register enables, mux select, ALU op and bus enable, and pulses `done` when the instruction retires. It replaces the free-running step counter plus combinational control with a handshaked, instruction-latched controller.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- `clock` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `iin` in 16: instruction; `[15:13]` opcode, `[12:10]` rX, `[9:7]` rY, `[8:0]` immediate field (sign-extended by the datapath).
- `instr_valid` in 1: `iin` holds a valid instruction.
- `instr_ready` out 1: sequencer can accept an instruction.
- `reg_enable` out 8: GPR write enables, MSB-first (`[7]`=r0 … `[0]`=r7).
- `A_enable` out 1: load A from bus.
- `R_enable` out 1: load R from ALU output.
- `selReg` out 4: bus mux select; 0..7 = r0..r7, 8 = R, 9 = immediate.
- `OpSelect` out 3: ALU operation.
- `bus_enable` out 1: drive mux output onto external bus.
- `done` out 1: one-cycle pulse in the instruction's final execution cycle.
- `illegal` out 1: only present with `SEQ_ILLEGAL_TRAP_EN`.

## Operation
- Opcodes:
  - 000 mv rX,rY
  - 001 mvi rX,#imm
  - 010 add, 011 sub, 100 and, 101 or, 110 slt (rX ← rX op rY)
  - 111 reserved
- ALU `OpSelect` = opcode for 010..110; `OpSelect` = 0 in all other cycles.
- States: IDLE, T1, T2, T3 (+ TRAP when the macro is defined).
- IDLE:
  - `instr_ready`=1; all enables 0; `selReg`=0.
  - On `instr_valid & instr_ready` at an edge: latch `iin` into an internal instruction register and go to T1. Later changes on `iin` are ignored.
- mv, T1: `selReg`=rY, `reg_enable`[rX]=1, `bus_enable`=1, `done`=1 → IDLE.
- mvi, T1: `selReg`=9, `reg_enable`[rX]=1, `bus_enable`=1, `done`=1 → IDLE.
- ALU op:
  - T1: `selReg`=rX, `A_enable`=1, `bus_enable`=1 → T2.
  - T2: `selReg`=rY, `OpSelect`=op, `R_enable`=1, `bus_enable`=1 → T3.
  - T3: `selReg`=8, `reg_enable`[rX]=1, `bus_enable`=1, `done`=1 → IDLE.
- rX==rY is legal; operands are read before writeback (`add r2,r2` doubles r2).
- At most one `reg_enable` bit is high in any cycle.
- `instr_valid` while busy is ignored. The requester holds the instruction until `instr_ready`.
- Outputs are a pure decode of (state, latched instruction), so they are glitch-free relative to `iin`.

## Timing
- Reset (`resetn`=0): state IDLE; all outputs 0, including `instr_ready` (gated by `resetn`) and `illegal`. Effect is immediate and asynchronous.
- Reset mid-instruction abandons it: enables drop at once, no `done`. Datapath register contents are left as they were.
- Accept edge E0.
- mv/mvi: GPR written at E1; `done` high during cycle E0–E1; `instr_ready` high again after E1. Throughput is 2 cycles per instruction.
- ALU ops: A loaded at E1, R at E2, rX at E3; `done` high during E2–E3. Throughput is 4 cycles per instruction.
- `instr_ready` is high only in IDLE, so there is no back-to-back accept in a done cycle.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - Opcode 111 goes to TRAP; `illegal`=1 sticky; `instr_ready`=0 and all enables 0 until reset.
  - No `done` pulse for the trapped instruction.
- Not defined:
  - Opcode 111 is a 1-cycle NOP: T1 with all enables 0, `done`=1 → IDLE.
  - No `illegal` port.

## Structure
- Shared package `proc_pkg`:
  - opcode constants;
  - `SEL_R`=4'd8, `SEL_IMM`=4'd9;
  - ALU op constants;
  - state encoding.
- One sub-module, `reg_onehot`: 3-bit index + enable → 8-bit MSB-first one-hot, instantiated for `reg_enable`.

## Test plan
- Reset, then `mvi r3,#5` (iin=16'h2C05) → T1: `selReg`=9, `reg_enable`=8'h10, `done`=1; `instr_ready` back after 2 cycles.
- `mv r0,r3` (iin=16'h0180) → `selReg`=3, `reg_enable`=8'h80, `done` in 1st execution cycle.
- `add r1,r2` (iin=16'h4500) → T1 `selReg`=1/`A_enable`; T2 `selReg`=2/`OpSelect`=3'b010/`R_enable`; T3 `selReg`=8/`reg_enable`=8'h40/`done`.
- `instr_valid` held high with a new `iin` during T2 of a sub → ignored; the latched sub completes; the new instruction is accepted only in IDLE.
- `resetn` pulsed low during T2 → all outputs 0 immediately; no `done`; IDLE with `instr_ready`=1 after release.
- Opcode 111:
  - macro on → `illegal`=1 and `instr_ready`=0 persist until reset;
  - macro off → single NOP cycle with `done`=1, no enables.
